ddr_write_burst_master: RTL and testbench
=========================================

// Module: ddr_write_burst_master
// PURPOSE
//  AXI4 write master downstream of the buffer-to-DDR write control. Takes one job (DDR start
//  address, byte length) per ddr_conf pulse, pops 256-bit words from the upstream write FIFO
//  (standard-mode FIFO, 1-cycle read latency), and issues INCR bursts of <=BURST_MAX beats,
//  never crossing a 4 KB boundary. Drives axi_ug_idle back to the upstream block.
// PARAMETERS
//  DDR_ADDR_LEN      32   DDR byte-address width
//  SINGLE_LEN        24   job byte-length width
//  C_AXI_DATA_WIDTH  256  data width (32 B/beat)
//  C_AXI_ID_WIDTH    4    AXI ID width; AWID constant 0
//  BURST_MAX         16   max beats per burst (1..256)
// PORTS
//  clk               in   1     clock
//  rst               in   1     asynchronous reset, active-high
//  ddr_conf          in   1     job start strobe, sampled only in IDLE
//  ddr_st_addr       in   DDR_ADDR_LEN  job start byte address
//  ddr_len           in   SINGLE_LEN    job length in bytes
//  ddr_write_empty   in   1     upstream FIFO empty
//  ddr_write_req     out  1     upstream FIFO pop; data valid next cycle
//  ddr_write_data    in   C_AXI_DATA_WIDTH  upstream FIFO dout
//  m_axi_awid/awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awvalid out, m_axi_awready in
//  m_axi_wdata/wstrb/wlast/wvalid out, m_axi_wready in
//  m_axi_bid/bresp[1:0]/bvalid in, m_axi_bready out
//  axi_ug_idle       out  1     no job active or pending
//  wr_err            out  1     sticky: a BRESP != OKAY seen in current job
// BEHAVIOUR
//  Reset: all valids/ready/req=0, awaddr=0, awlen=0, wlast=0, wr_err=0, axi_ug_idle=1, FSM=IDLE.
//  Constants: awsize=3'b101, awburst=2'b01, wstrb all ones, awid=0.
//  Job latch (IDLE & ddr_conf): addr={ddr_st_addr[DDR_ADDR_LEN-1:5],5'b0};
//   beats_left=ceil(ddr_len/32) (partial last beat written with full strobe); wr_err cleared.
//   ddr_len==0 -> stay IDLE, no AXI traffic. ddr_conf outside IDLE is ignored.
//  Burst size: nb=min(beats_left, BURST_MAX, (4096-addr[11:0])>>5); awlen=nb-1.
//  FSM: IDLE -> ADDR (awvalid=1 until awready) -> DATA (nb beats, wlast on beat nb)
//   -> RESP (bready=1 until bvalid) -> ADDR if beats_left>0 else IDLE.
//   addr+=nb*32 and beats_left-=nb on AW handshake. One burst outstanding; AW/W not overlapped.
//  awvalid/awaddr/awlen held stable until awready; wvalid/wdata held stable until wready.
//  Read path: ddr_write_req = !ddr_write_empty & (skid_count + req_inflight < 2)
//   & DATA-phase beats not yet requested > 0; popped word enters skid next cycle.
//   Never pops past the current burst's nb beats; never pops in IDLE/ADDR/RESP.
//  wvalid = skid non-empty & state==DATA; W beat counter resets on each AW handshake.
//  Upstream empty mid-burst: wvalid drops, wlast not advanced; resumes without loss.
//  Simultaneous skid push and W pop in same cycle: count unchanged, order preserved.
//  bresp!=2'b00 -> wr_err=1 (sticky to next job); burst sequence continues.
//  axi_ug_idle = (state==IDLE) & !ddr_conf, combinational.
//  rst asserted mid-job: immediate return to reset values; skid flushed; no completion.
// STRUCTURE
//  Shared package: AXI_BURST_INCR, AXI_RESP_OKAY, BYTES_PER_BEAT=C_AXI_DATA_WIDTH/8,
//   AXI_4K=4096, FSM state enum {IDLE,ADDR,DATA,RESP}.
//  Sub-module wr_skid_fifo2: 2-entry C_AXI_DATA_WIDTH register FIFO (push/pop/count/dout),
//   same clk/rst. Top holds FSM, burst sizing, beat/request counters.
// TESTING
//  1 addr=0x1000,len=1024, FIFO always full, ready=1 -> 2 bursts awlen=15, addrs 0x1000/0x1200, 32 W beats.
//  2 addr=0x0FC0,len=256 -> bursts awlen=1 @0x0FC0, awlen=5 @0x1000 (no 4 KB cross).
//  3 len=100 -> 1 burst awlen=3 (ceil), exactly 4 pops; len=0 -> no AW, idle stays 1.
//  4 random wready/awready/bvalid + random ddr_write_empty -> data order intact, pops == beats.
//  5 bresp=2'b10 on burst 1 of 2 -> wr_err=1, burst 2 still issued; cleared by next ddr_conf.
//  6 rst pulse during DATA beat 5 -> all outputs at reset values same cycle, idle=1 after release.

Source files
------------

// File: rtl/ddr_write_burst_master_pkg.sv
// Shared widths, AXI constants, FSM states and burst sizing for the DDR write burst master.
package ddr_write_burst_master_pkg;

  localparam int unsigned DDR_ADDR_LEN     = 32;
  localparam int unsigned SINGLE_LEN       = 24;
  localparam int unsigned C_AXI_DATA_WIDTH = 256;
  localparam int unsigned C_AXI_ID_WIDTH   = 4;
  localparam int unsigned BURST_MAX        = 16;
  localparam int unsigned BYTES_PER_BEAT   = C_AXI_DATA_WIDTH / 8;
  localparam int unsigned BEAT_SHIFT       = $clog2(BYTES_PER_BEAT);
  localparam int unsigned AXI_4K           = 4096;
  localparam int unsigned BEATS_W          = SINGLE_LEN - BEAT_SHIFT + 1;
  localparam int unsigned NB_W             = 9;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_BEAT  = 3'(BEAT_SHIFT);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  typedef struct packed {
    logic [DDR_ADDR_LEN-1:0] addr;
    logic [7:0]              len;
  } aw_req_t;

  // Beats in the next burst: limited by remaining job, BURST_MAX and the 4 KB page.
  function automatic logic [NB_W-1:0] burst_beats(input logic [11:0]         addr_lo,
                                                  input logic [BEATS_W-1:0]  beats_left);
    logic [12:0]     room_bytes;
    logic [NB_W-1:0] n;
    room_bytes = 13'(AXI_4K) - {1'b0, addr_lo};
    n = NB_W'(room_bytes >> BEAT_SHIFT);
    if (n > NB_W'(BURST_MAX)) n = NB_W'(BURST_MAX);
    if (BEATS_W'(n) > beats_left) n = NB_W'(beats_left);
    return n;
  endfunction

endpackage

// File: rtl/ddr_write_burst_master_if.sv
// Job, upstream FIFO and AXI4 write-channel signals of the DDR write burst master.
interface ddr_write_burst_master_if;
  import ddr_write_burst_master_pkg::*;

  logic                          ddr_conf;
  logic [DDR_ADDR_LEN-1:0]       ddr_st_addr;
  logic [SINGLE_LEN-1:0]         ddr_len;
  logic                          ddr_write_empty;
  logic                          ddr_write_req;
  logic [C_AXI_DATA_WIDTH-1:0]   ddr_write_data;

  logic [C_AXI_ID_WIDTH-1:0]     m_axi_awid;
  logic [DDR_ADDR_LEN-1:0]       m_axi_awaddr;
  logic [7:0]                    m_axi_awlen;
  logic [2:0]                    m_axi_awsize;
  logic [1:0]                    m_axi_awburst;
  logic                          m_axi_awvalid;
  logic                          m_axi_awready;

  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata;
  logic [BYTES_PER_BEAT-1:0]     m_axi_wstrb;
  logic                          m_axi_wlast;
  logic                          m_axi_wvalid;
  logic                          m_axi_wready;

  logic [C_AXI_ID_WIDTH-1:0]     m_axi_bid;
  logic [1:0]                    m_axi_bresp;
  logic                          m_axi_bvalid;
  logic                          m_axi_bready;

  logic                          axi_ug_idle;
  logic                          wr_err;

  modport master (
    input  ddr_conf, ddr_st_addr, ddr_len, ddr_write_empty, ddr_write_data,
           m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output ddr_write_req, m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
           m_axi_awburst, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
           m_axi_wvalid, m_axi_bready, axi_ug_idle, wr_err
  );

  modport slave (
    output ddr_conf, ddr_st_addr, ddr_len, ddr_write_empty, ddr_write_data,
           m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  ddr_write_req, m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
           m_axi_awburst, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
           m_axi_wvalid, m_axi_bready, axi_ug_idle, wr_err
  );

endinterface

// File: rtl/ddr_write_burst_master_wr_skid_fifo2.sv
// Two-entry register FIFO that absorbs the upstream FIFO's one-cycle read latency.
module wr_skid_fifo2
  import ddr_write_burst_master_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [C_AXI_DATA_WIDTH-1:0] din,
  input  logic                        pop,
  output logic [1:0]                  count,
  output logic [C_AXI_DATA_WIDTH-1:0] dout
);

  logic [C_AXI_DATA_WIDTH-1:0] mem_q [2];
  logic                        wr_ptr_q;
  logic                        rd_ptr_q;
  logic [1:0]                  count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ddr_write_burst_master.sv
// AXI4 write master: splits one DDR write job into 4 KB-safe INCR bursts fed from the upstream FIFO.
module ddr_write_burst_master
  import ddr_write_burst_master_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  ddr_write_burst_master_if.master  bus
);

  state_e                      state_q, state_d;
  logic [DDR_ADDR_LEN-1:0]     addr_q;
  logic [BEATS_W-1:0]          beats_left_q;
  logic [NB_W-1:0]             burst_nb_q;
  logic [NB_W-1:0]             w_cnt_q;
  logic [NB_W-1:0]             req_cnt_q;
  logic                        inflight_q;
  logic                        wr_err_q;

  logic [NB_W-1:0]             nb_c;
  aw_req_t                     aw_c;
  logic                        job_c;
  logic                        req_c;
  logic                        wvalid_c;
  logic                        wlast_c;
  logic                        aw_hs, w_hs, b_hs;
  logic [1:0]                  skid_count;
  logic [C_AXI_DATA_WIDTH-1:0] skid_dout;
  logic                        unused_bid;

  assign unused_bid = ^bus.m_axi_bid;

  assign nb_c     = burst_beats(addr_q[11:0], beats_left_q);
  assign aw_c.addr = addr_q;
  assign aw_c.len  = (nb_c == NB_W'(0)) ? 8'd0 : 8'(nb_c - NB_W'(1));

  assign job_c    = bus.ddr_conf & (state_q == IDLE);
  assign wvalid_c = (state_q == DATA) & (skid_count != 2'd0);
  assign wlast_c  = wvalid_c & (w_cnt_q == (burst_nb_q - NB_W'(1)));
  assign aw_hs    = (state_q == ADDR) & bus.m_axi_awready;
  assign w_hs     = wvalid_c & bus.m_axi_wready;
  assign b_hs     = (state_q == RESP) & bus.m_axi_bvalid;

  // Pop only while the skid plus the in-flight read still fits and the burst needs more beats.
  assign req_c = (state_q == DATA) & ~bus.ddr_write_empty
               & (({1'b0, skid_count} + {2'b00, inflight_q}) < 3'd2)
               & (req_cnt_q < burst_nb_q);

  wr_skid_fifo2 u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (bus.ddr_write_data),
    .pop   (w_hs),
    .count (skid_count),
    .dout  (skid_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    bus.m_axi_awvalid = 1'b0;
    bus.m_axi_wvalid  = 1'b0;
    bus.m_axi_wlast   = 1'b0;
    bus.m_axi_bready  = 1'b0;
    case (state_q)
      IDLE: if (job_c && (bus.ddr_len != SINGLE_LEN'(0))) state_d = ADDR;
      ADDR: begin
        bus.m_axi_awvalid = 1'b1;
        if (bus.m_axi_awready) state_d = DATA;
      end
      DATA: begin
        bus.m_axi_wvalid = wvalid_c;
        bus.m_axi_wlast  = wlast_c;
        if (w_hs && wlast_c) state_d = RESP;
      end
      RESP: begin
        bus.m_axi_bready = 1'b1;
        if (bus.m_axi_bvalid) state_d = (beats_left_q != BEATS_W'(0)) ? ADDR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job, burst and beat bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      beats_left_q <= '0;
      burst_nb_q   <= '0;
      w_cnt_q      <= '0;
      req_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      inflight_q <= req_c;
      if (job_c) begin
        addr_q       <= bus.ddr_st_addr & ~DDR_ADDR_LEN'(BYTES_PER_BEAT - 1);
        beats_left_q <= BEATS_W'((DDR_ADDR_LEN'(bus.ddr_len)
                                  + DDR_ADDR_LEN'(BYTES_PER_BEAT - 1)) >> BEAT_SHIFT);
        wr_err_q     <= 1'b0;
      end
      if (aw_hs) begin
        addr_q       <= addr_q + (DDR_ADDR_LEN'(nb_c) << BEAT_SHIFT);
        beats_left_q <= beats_left_q - BEATS_W'(nb_c);
        burst_nb_q   <= nb_c;
        w_cnt_q      <= '0;
        req_cnt_q    <= '0;
      end else begin
        if (req_c) req_cnt_q <= req_cnt_q + NB_W'(1);
        if (w_hs)  w_cnt_q   <= w_cnt_q + NB_W'(1);
      end
      if (b_hs && (bus.m_axi_bresp != AXI_RESP_OKAY)) wr_err_q <= 1'b1;
    end
  end

  assign bus.m_axi_awid    = '0;
  assign bus.m_axi_awaddr  = aw_c.addr;
  assign bus.m_axi_awlen   = aw_c.len;
  assign bus.m_axi_awsize  = AXI_SIZE_BEAT;
  assign bus.m_axi_awburst = AXI_BURST_INCR;
  assign bus.m_axi_wdata   = skid_dout;
  assign bus.m_axi_wstrb   = '1;
  assign bus.ddr_write_req = req_c;
  assign bus.wr_err        = wr_err_q;
  assign bus.axi_ug_idle   = (state_q == IDLE) & ~bus.ddr_conf;

endmodule

// File: tb/tb_ddr_write_burst_master.sv
// Scoreboard bench for ddr_write_burst_master: random AXI/FIFO back-pressure against a job-level model.
module tb_ddr_write_burst_master;
  import ddr_write_burst_master_pkg::*;

  typedef logic [C_AXI_DATA_WIDTH-1:0] word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr_write_burst_master_if bus();

  ddr_write_burst_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  word_t       src_q[$];
  word_t       exp_w_q[$];
  bit          exp_last_q[$];
  logic [39:0] exp_aw_q[$];

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int w_beats = 0;
  int b_count = 0;
  int outstanding = 0;
  int err_burst = -1;
  bit rnd_mode = 1'b0;
  bit pop_now = 1'b0;
  bit b_done = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // AXI slave, upstream FIFO flags and scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      bus.m_axi_awready   = 1'b0;
      bus.m_axi_wready    = 1'b0;
      bus.m_axi_bvalid    = 1'b0;
      bus.m_axi_bresp     = 2'b00;
      bus.m_axi_bid       = '0;
      bus.ddr_write_empty = 1'b1;
      outstanding = 0;
      b_done = 1'b0;
      exp_aw_q.delete();
      exp_w_q.delete();
      exp_last_q.delete();
    end else begin
      if (b_done) begin
        bus.m_axi_bvalid = 1'b0;
        b_done = 1'b0;
      end
      bus.m_axi_awready   = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.m_axi_wready    = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.ddr_write_empty = (src_q.size() == 0) || (rnd_mode && $urandom_range(0, 3) == 0);
      if (!bus.m_axi_bvalid && outstanding > 0 && (!rnd_mode || $urandom_range(0, 2) == 0)) begin
        bus.m_axi_bvalid = 1'b1;
        bus.m_axi_bresp  = (b_count == err_burst) ? 2'b10 : 2'b00;
      end
      #1;
      if (!rst) begin
        if (bus.m_axi_awvalid && bus.m_axi_awready) begin
          if (exp_aw_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL aw_unexpected actual=%0h required=none", bus.m_axi_awaddr);
          end else begin
            check("aw_addr_len", {bus.m_axi_awaddr, bus.m_axi_awlen}, exp_aw_q.pop_front());
          end
          check("aw_const", {bus.m_axi_awid, bus.m_axi_awsize, bus.m_axi_awburst},
                {4'd0, 3'b101, 2'b01});
        end
        if (bus.m_axi_wvalid && bus.m_axi_wready) begin
          if (exp_w_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL w_unexpected actual=%0h required=none", bus.m_axi_wdata);
          end else begin
            check("w_data", bus.m_axi_wdata, exp_w_q.pop_front());
            check("w_last", bus.m_axi_wlast, exp_last_q.pop_front());
          end
          check("w_strb", bus.m_axi_wstrb, {BYTES_PER_BEAT{1'b1}});
          w_beats++;
          if (bus.m_axi_wlast) outstanding++;
        end
        if (bus.m_axi_bvalid && bus.m_axi_bready) begin
          outstanding--;
          b_count++;
          b_done = 1'b1;
        end
        if (bus.ddr_write_req) begin
          check("req_while_empty", bus.ddr_write_empty, 1'b0);
          pop_now = 1'b1;
          pops++;
        end
      end
    end
  end

  // Upstream standard-mode FIFO: dout updates one cycle after a sampled pop.
  always @(posedge clk) begin
    if (rst) begin
      src_q.delete();
      pop_now = 1'b0;
    end else if (pop_now) begin
      #1;
      pop_now = 1'b0;
      if (src_q.size() > 0) bus.ddr_write_data = src_q.pop_front();
    end
  end

  int job_beats;
  int job_bursts;

  // Job-level reference: split into bursts and queue expected AW/W plus the upstream words.
  task automatic start_job(input int unsigned addr, input int unsigned len, input int err_rel);
    int unsigned a;
    int beats, nb, room;
    word_t w;
    a = addr & ~32'h1F;
    beats = int'((len + 31) / 32);
    job_beats = beats;
    job_bursts = 0;
    while (beats > 0) begin
      room = int'((4096 - (a % 4096)) / 32);
      nb = beats;
      if (nb > int'(BURST_MAX)) nb = int'(BURST_MAX);
      if (nb > room) nb = room;
      exp_aw_q.push_back({a, 8'(nb - 1)});
      for (int j = 0; j < nb; j++) begin
        for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom;
        src_q.push_back(w);
        exp_w_q.push_back(w);
        exp_last_q.push_back(j == nb - 1);
      end
      a += 32'(nb * 32);
      beats -= nb;
      job_bursts++;
    end
    err_burst = (err_rel < 0) ? -1 : b_count + err_rel;
    @(negedge clk);
    bus.ddr_conf    = 1'b1;
    bus.ddr_st_addr = addr;
    bus.ddr_len     = SINGLE_LEN'(len);
    #1 check("idle_drops_on_conf", bus.axi_ug_idle, 1'b0);
    @(negedge clk);
    bus.ddr_conf = 1'b0;
    #1 check("wr_err_cleared_on_conf", bus.wr_err, 1'b0);
  endtask

  task automatic run_job(input int unsigned addr, input int unsigned len, input int err_rel,
                         input bit rnd);
    int p0;
    bit done;
    bit exp_err;
    rnd_mode = rnd;
    p0 = pops;
    start_job(addr, len, err_rel);
    exp_err = (err_rel >= 0) && (err_rel < job_bursts);
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      #2;
      if (bus.axi_ug_idle) done = 1'b1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL job_timeout actual=busy required=idle");
    end
    check("aw_all_issued", exp_aw_q.size(), 0);
    check("w_all_sent", exp_w_q.size(), 0);
    check("pops_eq_beats", pops - p0, job_beats);
    check("wr_err_final", bus.wr_err, exp_err);
  endtask

  task automatic check_reset_outputs();
    check("rst_ctrl", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.ddr_write_req,
                       bus.m_axi_wlast, bus.wr_err, bus.axi_ug_idle}, 7'b0000001);
    check("rst_awaddr", bus.m_axi_awaddr, 0);
    check("rst_awlen", bus.m_axi_awlen, 0);
  endtask

  initial begin
    int w0;
    bit hit;
    bus.ddr_conf       = 1'b0;
    bus.ddr_st_addr    = '0;
    bus.ddr_len        = '0;
    rst = 1'b1;
    @(negedge clk);
    #2 check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    run_job(32'h0000_1000, 1024, -1, 1'b0);
    run_job(32'h0000_0FC0, 256, -1, 1'b0);
    run_job(32'h0000_0500, 100, -1, 1'b0);
    run_job(32'h0000_0700, 0, -1, 1'b0);
    check("idle_after_len0", bus.axi_ug_idle, 1'b1);

    run_job(32'h0000_2000, 1024, 0, 1'b0);
    for (int n = 0; n < 6; n++)
      run_job($urandom & 32'h000F_FFFF, $urandom_range(1, 2500), -1, 1'b1);
    run_job(32'h0001_0F80, 700, 1, 1'b1);

    // Reset in the middle of a data phase.
    rnd_mode = 1'b0;
    w0 = w_beats;
    start_job(32'h0000_3000, 2048, -1);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      #2;
      if (w_beats - w0 >= 5) hit = 1'b1;
    end
    if (!hit) begin
      checks++; failures++;
      $display("FAIL reset_setup_timeout actual=%0d required=5", w_beats - w0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check_reset_outputs();

    run_job(32'h0000_4040, 600, -1, 1'b1);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
